// File: rtl/mc_mv_rd_arb_pkg.sv
// mc_mv_rd_arb_pkg
//   Shared definitions for the MV buffer read-port arbiter.
//   - FMV_WIDTH: width of one motion-vector component. An MV word is two of these.
//   - arb_mode_e / MV_ARB_*: arbitration mode encodings as seen on mode_i.
//   - decode_mode(): folds the spare encoding 2'b11 onto fixed priority.
package mc_mv_rd_arb_pkg;

  localparam int FMV_WIDTH = 10;

  localparam logic [1:0] MV_ARB_FIXED = 2'b00;
  localparam logic [1:0] MV_ARB_RR    = 2'b01;
  localparam logic [1:0] MV_ARB_FORCE = 2'b10;

  typedef enum logic [1:0] {
    ARB_FIXED = 2'b00,
    ARB_RR    = 2'b01,
    ARB_FORCE = 2'b10
  } arb_mode_e;

  // 2'b11 is not a mode of its own; it behaves exactly like fixed priority.
  function automatic arb_mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      MV_ARB_RR:    return ARB_RR;
      MV_ARB_FORCE: return ARB_FORCE;
      default:      return ARB_FIXED;
    endcase
  endfunction

endpackage

// File: rtl/mc_mv_rd_arb_rr_pick.sv
// mc_rr_pick
//   Rotate-priority one-hot picker. Scans the request vector starting at
//   start_ptr and wrapping modulo NUM_CLIENTS; the first requester found wins.
//   With start_ptr = 0 it degenerates to a fixed lowest-index-first picker.
// Ports
//   req        in   NUM_CLIENTS  active-high requests
//   start_ptr  in   IW           index that gets highest priority (< NUM_CLIENTS)
//   onehot     out  NUM_CLIENTS  one-hot winner, all zero when nobody requests
//   idx        out  IW           binary index of the winner (0 when none)
//   found      out  1            at least one requester exists
module mc_rr_pick #(
  parameter int NUM_CLIENTS = 2,
  parameter int IW          = 1
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IW-1:0]          start_ptr,
  output logic [NUM_CLIENTS-1:0] onehot,
  output logic [IW-1:0]          idx,
  output logic                   found
);

  // One extra bit holds start_ptr + k before the modulo fold, which matters
  // when NUM_CLIENTS is a power of two and the sum overflows IW bits.
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      sum = {1'b0, start_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_CLIENTS)) begin
        sum = sum - (IW+1)'(NUM_CLIENTS);
      end
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/mc_mv_rd_arb.sv
// mc_mv_rd_arb
//   N-client arbiter for the single read port of the FME MV buffer.
//   Modes: fixed priority (lowest index wins), round-robin with bounded burst
//   locking, and forced owner. Per-client enable polarity is normalised
//   internally; read data comes back tagged to the client that was granted.
// Ports
//   clk, rstn      clock, asynchronous active-low reset
//   mode_i         00 fixed, 01 round-robin, 10 forced, 11 fixed
//   force_id_i     owner in forced mode (out of range grants nobody)
//   cli_rden_i     per-client read request, polarity per ACT_LOW_MASK
//   cli_rdaddr_i   packed client addresses, client i at [i*AW +: AW]
//   cli_gnt_o      one-hot grant, combinational, same cycle as request
//   cli_rvalid_o   one-hot data valid, RD_LATENCY cycles after the grant
//   cli_rdata_o    shared read data, zero when no rvalid
//   mv_rden_o      MV buffer read enable (active-high)
//   mv_rdaddr_o    MV buffer read address, zero when nothing granted
//   mv_data_i      MV buffer read data
//   deny_cnt_o     saturating count of cycles with at least one denied request
module mc_mv_rd_arb
  import mc_mv_rd_arb_pkg::*;
#(
  parameter int                     NUM_CLIENTS  = 2,
  parameter int                     ADDR_WIDTH   = 6,
  parameter int                     DATA_WIDTH   = 2*FMV_WIDTH,
  parameter int                     RD_LATENCY   = 1,
  parameter logic [NUM_CLIENTS-1:0] ACT_LOW_MASK = 2'b10,
  parameter int                     MAX_BURST    = 16,
  parameter int                     CNT_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [1:0]                        mode_i,
  input  logic [$clog2(NUM_CLIENTS)-1:0]    force_id_i,
  input  logic [NUM_CLIENTS-1:0]            cli_rden_i,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cli_rdaddr_i,
  output logic [NUM_CLIENTS-1:0]            cli_gnt_o,
  output logic [NUM_CLIENTS-1:0]            cli_rvalid_o,
  output logic [DATA_WIDTH-1:0]             cli_rdata_o,
  output logic                              mv_rden_o,
  output logic [ADDR_WIDTH-1:0]             mv_rdaddr_o,
  input  logic [DATA_WIDTH-1:0]             mv_data_i,
  output logic [CNT_WIDTH-1:0]              deny_cnt_o
);

  localparam int IW = $clog2(NUM_CLIENTS);
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [NUM_CLIENTS-1:0] req;
  arb_mode_e              mode;
  logic                   mode_chg;

  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          owner;
  logic                   lock;
  logic [BW-1:0]          burst_cnt;
  logic [1:0]             mode_q;

  logic                   lock_eff;
  logic                   keep;
  logic                   force_ok;
  logic [IW-1:0]          start_ptr;
  logic [NUM_CLIENTS-1:0] pick_oh;
  logic [IW-1:0]          pick_idx;
  logic                   pick_found;

  logic [NUM_CLIENTS-1:0] gnt;
  logic [IW-1:0]          gnt_idx;
  logic                   new_grant;
  logic [IW-1:0]          next_ptr;

  logic [NUM_CLIENTS-1:0] vld_pipe [RD_LATENCY];

  assign req  = cli_rden_i ^ ACT_LOW_MASK;
  assign mode = decode_mode(mode_i);

  // A mode change must drop any burst lock in the very cycle it happens, so the
  // registered lock is masked here rather than waiting for it to clear.
  assign mode_chg = (mode_i != mode_q);
  assign lock_eff = lock & ~mode_chg;

  // The owner keeps the port while it still asks and has burst budget left.
  assign keep = (mode == ARB_RR) & lock_eff & req[owner] &
                (burst_cnt < BW'(MAX_BURST));

  assign force_ok  = ({1'b0, force_id_i} < (IW+1)'(NUM_CLIENTS));
  assign start_ptr = (mode == ARB_RR) ? rr_ptr : '0;

  mc_rr_pick #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IW          (IW)
  ) u_pick (
    .req       (req),
    .start_ptr (start_ptr),
    .onehot    (pick_oh),
    .idx       (pick_idx),
    .found     (pick_found)
  );

  // Grant selection. In round-robin, the picker starts at rr_ptr, which after
  // a grant to k points at k+1; so when the owner exhausts its burst the scan
  // naturally reaches other requesters first and only wraps back to the owner
  // if nobody else is asking.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    new_grant = 1'b0;
    case (mode)
      ARB_RR: begin
        if (keep) begin
          gnt[owner] = 1'b1;
          gnt_idx    = owner;
        end else if (pick_found) begin
          gnt       = pick_oh;
          gnt_idx   = pick_idx;
          new_grant = 1'b1;
        end
      end
      ARB_FORCE: begin
        if (force_ok && req[force_id_i]) begin
          gnt[force_id_i] = 1'b1;
          gnt_idx         = force_id_i;
        end
      end
      default: begin
        gnt     = pick_oh;
        gnt_idx = pick_idx;
      end
    endcase
  end

  assign next_ptr = (gnt_idx == IW'(NUM_CLIENTS - 1)) ? '0 : gnt_idx + 1'b1;

  // Address mux: grant is one-hot, so at most one slice is selected and the
  // address stays zero when nobody is granted.
  always_comb begin
    mv_rdaddr_o = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (gnt[i]) begin
        mv_rdaddr_o = cli_rdaddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign cli_gnt_o = gnt;
  assign mv_rden_o = |gnt;

  // Arbitration state. Only round-robin uses the lock; the other modes keep it
  // cleared so that switching back to round-robin always starts a fresh search.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr    <= '0;
      owner     <= '0;
      lock      <= 1'b0;
      burst_cnt <= '0;
      mode_q    <= MV_ARB_FIXED;
    end else begin
      mode_q <= mode_i;
      if (mode == ARB_RR) begin
        if (keep) begin
          burst_cnt <= burst_cnt + 1'b1;
        end else if (new_grant) begin
          owner     <= gnt_idx;
          lock      <= 1'b1;
          burst_cnt <= BW'(1);
          rr_ptr    <= next_ptr;
        end else begin
          lock      <= 1'b0;
          burst_cnt <= '0;
        end
      end else begin
        lock      <= 1'b0;
        burst_cnt <= '0;
      end
    end
  end

  // Return path: the grant vector travels alongside the buffer access so the
  // data can be tagged to its client. Reset flushes it, dropping in-flight reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= gnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign cli_rvalid_o = vld_pipe[RD_LATENCY-1];
  assign cli_rdata_o  = (|cli_rvalid_o) ? mv_data_i : '0;

  // Contention monitor: counts cycles where some requester went unserved.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deny_cnt_o <= '0;
    end else if ((|(req & ~gnt)) && (deny_cnt_o != '1)) begin
      deny_cnt_o <= deny_cnt_o + 1'b1;
    end
  end

endmodule
